// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: opcode encodings, flag bit
// positions, FSM state type and the per-opcode flag mask.
package alu_issue_stage_pkg;

  localparam logic [2:0] OP_SLA = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam int ZF = 0;
  localparam int OF = 1;
  localparam int NF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Flags the ALU leaves undefined (possibly high-impedance) are forced to
  // constant zero so no unknown value can propagate into the captured flags.
  function automatic logic [2:0] mask_flags(input logic [2:0] op,
                                            input logic [2:0] flags);
    logic [2:0] masked;
    masked = flags;
    case (op)
      OP_AND, OP_OR, OP_NOT: begin
        masked[NF] = 1'b0;
        masked[OF] = 1'b0;
      end
      OP_SRA:  masked[OF] = 1'b0;
      default: masked = flags;
    endcase
    return masked;
  endfunction

endpackage

// File: rtl/alu_issue_stage_wait_ctr.sv
// Loadable 4-bit down-counter that times the ALU settle interval; the zero
// flag tells the issue stage the result may be captured.
module alu_issue_stage_wait_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_loadVal,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_count;

  // A load takes priority so a back-to-back accept restarts the interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue/capture stage around an external combinational ALU:
// holds operands stable for a settle interval, then captures result and flags.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DW       = 32,
  parameter int ALU_WAIT = 1,
  parameter int MUL_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [2:0]    in_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_c,
  input  logic [2:0]    alu_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_c,
  output logic [2:0]    out_d,
  output logic [2:0]    sticky_d,
  input  logic          sticky_clr,
  output logic          busy
);

  localparam logic [3:0] ALU_LOAD = 4'(ALU_WAIT - 1);
  localparam logic [3:0] MUL_LOAD = 4'(MUL_WAIT - 1);

  state_e        r_state;
  state_e        w_stateNext;
  logic [DW-1:0] r_aluA;
  logic [DW-1:0] r_aluB;
  logic [2:0]    r_aluOp;
  logic [DW-1:0] r_outC;
  logic [2:0]    r_outD;
  logic [2:0]    r_sticky;

  logic          w_inReady;
  logic          w_accept;
  logic          w_capture;
  logic          w_ctrZero;
  logic          w_ctrDec;
  logic [3:0]    w_ctrLoadVal;
  logic [2:0]    w_maskedFlags;

  assign w_inReady     = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
  assign w_accept      = in_valid && w_inReady;
  assign w_capture     = (r_state == ST_EXEC) && w_ctrZero;
  assign w_ctrDec      = (r_state == ST_EXEC) && !w_ctrZero;
  assign w_ctrLoadVal  = (in_op == OP_MUL) ? MUL_LOAD : ALU_LOAD;
  assign w_maskedFlags = mask_flags(r_aluOp, alu_d);

  alu_issue_stage_wait_ctr u_waitCtr (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_loadVal (w_ctrLoadVal),
    .i_dec     (w_ctrDec),
    .o_zero    (w_ctrZero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_stateNext = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_ctrZero) begin
          w_stateNext = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_stateNext = in_valid ? ST_EXEC : ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Operands only move on accept, keeping the ALU inputs quiet while it settles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aluA  <= '0;
      r_aluB  <= '0;
      r_aluOp <= 3'b000;
    end else if (w_accept) begin
      r_aluA  <= in_a;
      r_aluB  <= in_b;
      r_aluOp <= in_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outC <= '0;
      r_outD <= 3'b000;
    end else if (w_capture) begin
      r_outC <= alu_c;
      r_outD <= w_maskedFlags;
    end
  end

  // A capture coinciding with a clear keeps the new flags rather than losing them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= 3'b000;
    end else if (w_capture) begin
      r_sticky <= (sticky_clr ? 3'b000 : r_sticky) | w_maskedFlags;
    end else if (sticky_clr) begin
      r_sticky <= 3'b000;
    end
  end

  assign in_ready  = w_inReady;
  assign alu_a     = r_aluA;
  assign alu_b     = r_aluB;
  assign alu_op    = r_aluOp;
  assign out_valid = (r_state == ST_HOLD);
  assign out_c     = r_outC;
  assign out_d     = r_outD;
  assign sticky_d  = r_sticky;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a behavioural ALU closes the loop and a
// vector table plus hand-written sequences check latency, capture and flags.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_c;
  logic [2:0]  alu_d;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_c;
  logic [2:0]  out_d;
  logic [2:0]  sticky_d;
  logic        sticky_clr;
  logic        busy;

  int checks;
  int errors;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          clrFirst;
    int          expLat;
    logic [31:0] expC;
    logic [2:0]  expD;
    logic [2:0]  expSticky;
  } vec_t;

  vec_t vecs[11];

  alu_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_c      (alu_c),
    .alu_d      (alu_d),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_c      (out_c),
    .out_d      (out_d),
    .sticky_d   (sticky_d),
    .sticky_clr (sticky_clr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; undefined flags are driven high so an unmasked bit is visible.
  logic [63:0] prod;
  always_comb begin
    prod  = {{32{alu_a[31]}}, alu_a} * {{32{alu_b[31]}}, alu_b};
    alu_c = 32'd0;
    alu_d = 3'b000;
    case (alu_op)
      OP_SLA: alu_c = alu_a << alu_b[4:0];
      OP_SRA: begin
        alu_c     = $signed(alu_a) >>> alu_b[4:0];
        alu_d[OF] = 1'b1;
      end
      OP_ADD: begin
        alu_c     = alu_a + alu_b;
        alu_d[OF] = (alu_a[31] == alu_b[31]) && (alu_c[31] != alu_a[31]);
      end
      OP_SUB: begin
        alu_c     = alu_a - alu_b;
        alu_d[OF] = (alu_a[31] != alu_b[31]) && (alu_c[31] != alu_a[31]);
      end
      OP_MUL: begin
        alu_c     = prod[31:0];
        alu_d[OF] = (prod[63:32] != {32{prod[31]}});
      end
      OP_AND: alu_c = alu_a & alu_b;
      OP_OR:  alu_c = alu_a | alu_b;
      default: alu_c = ~alu_a;
    endcase
    alu_d[ZF] = (alu_c == 32'd0);
    if (alu_op == OP_AND || alu_op == OP_OR || alu_op == OP_NOT) begin
      alu_d[NF] = 1'b1;
      alu_d[OF] = 1'b1;
    end else begin
      alu_d[NF] = alu_c[31];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Presents one request at posedge+1 and returns one step after the accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    #1;
    checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitForResult(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, output int cycles,
                               output bit stable);
    cycles = 0;
    stable = 1'b1;
    while (!out_valid && cycles < 20) begin
      if (alu_a !== a || alu_b !== b || alu_op !== op) stable = 1'b0;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (alu_a !== a || alu_b !== b || alu_op !== op) stable = 1'b0;
  endtask

  int cycles;
  bit stable;
  bit sawValid;

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_a       = 32'd0;
    in_b       = 32'd0;
    in_op      = OP_ADD;
    out_ready  = 1'b1;
    sticky_clr = 1'b0;

    vecs[0]  = '{OP_ADD, 32'd7,        32'hFFFFFFF9, 1'b0, 1, 32'd0,        3'b001, 3'b001};
    vecs[1]  = '{OP_ADD, 32'h7FFFFFFF, 32'd1,        1'b0, 1, 32'h80000000, 3'b110, 3'b111};
    vecs[2]  = '{OP_MUL, 32'd6,        32'd7,        1'b1, 4, 32'd42,       3'b000, 3'b000};
    vecs[3]  = '{OP_AND, 32'h000000F0, 32'h0000000F, 1'b0, 1, 32'd0,        3'b001, 3'b001};
    vecs[4]  = '{OP_SRA, 32'd2,        32'd1,        1'b0, 1, 32'd1,        3'b000, 3'b001};
    vecs[5]  = '{OP_SUB, 32'h80000000, 32'd1,        1'b0, 1, 32'h7FFFFFFF, 3'b010, 3'b011};
    vecs[6]  = '{OP_NOT, 32'd0,        32'd0,        1'b1, 1, 32'hFFFFFFFF, 3'b000, 3'b000};
    vecs[7]  = '{OP_OR,  32'd0,        32'd0,        1'b0, 1, 32'd0,        3'b001, 3'b001};
    vecs[8]  = '{OP_SLA, 32'd1,        32'd31,       1'b0, 1, 32'h80000000, 3'b100, 3'b101};
    vecs[9]  = '{OP_MUL, 32'h00010000, 32'h00010000, 1'b0, 4, 32'd0,        3'b011, 3'b111};
    vecs[10] = '{OP_MUL, 32'hFFFFFFFD, 32'd5,        1'b1, 4, 32'hFFFFFFF1, 3'b100, 3'b100};

    #2;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_busy",      {31'd0, busy},      32'd0);
    checkOutput("reset_alu_a",     alu_a,              32'd0);
    checkOutput("reset_alu_b",     alu_b,              32'd0);
    checkOutput("reset_alu_op",    {29'd0, alu_op},    32'd0);
    checkOutput("reset_out_c",     out_c,              32'd0);
    checkOutput("reset_out_d",     {29'd0, out_d},     32'd0);
    checkOutput("reset_sticky",    {29'd0, sticky_d},  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].clrFirst) begin
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
      end
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitForResult(vecs[i].a, vecs[i].b, vecs[i].op, cycles, stable);
      checkOutput($sformatf("vec%0d_latency", i), 32'(cycles), 32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d_alu_stable", i), {31'd0, stable}, 32'd1);
      checkOutput($sformatf("vec%0d_out_c", i), out_c, vecs[i].expC);
      checkOutput($sformatf("vec%0d_out_d", i), {29'd0, out_d}, {29'd0, vecs[i].expD});
      checkOutput($sformatf("vec%0d_sticky", i), {29'd0, sticky_d}, {29'd0, vecs[i].expSticky});
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_released", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure in HOLD, then same-edge transfer and accept.
    out_ready = 1'b0;
    applyStimulus(OP_ADD, 32'd10, 32'd20);
    waitForResult(32'd10, 32'd20, OP_ADD, cycles, stable);
    checkOutput("bp_latency", 32'(cycles), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold%0d_valid", k), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("bp_hold%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      checkOutput($sformatf("bp_hold%0d_out_c", k), out_c, 32'd30);
    end
    out_ready = 1'b1;
    applyStimulus(OP_SUB, 32'd5, 32'd3);
    checkOutput("b2b_out_valid_dropped", {31'd0, out_valid}, 32'd0);
    checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
    checkOutput("b2b_alu_a", alu_a, 32'd5);
    @(posedge clk);
    #1;
    checkOutput("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("b2b_out_c", out_c, 32'd2);
    @(posedge clk);
    #1;
    checkOutput("b2b_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a mul discards it.
    applyStimulus(OP_MUL, 32'd6, 32'd7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid_sticky", {29'd0, sticky_d}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_alu_a", alu_a, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sawValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("rst_no_result", {31'd0, sawValid}, 32'd0);

    // Clear coinciding with an overflow capture keeps the new flags.
    applyStimulus(OP_ADD, 32'd7, 32'hFFFFFFF9);
    waitForResult(32'd7, 32'hFFFFFFF9, OP_ADD, cycles, stable);
    checkOutput("clr_pre_sticky", {29'd0, sticky_d}, 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(OP_ADD, 32'h7FFFFFFF, 32'd1);
    sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    sticky_clr = 1'b0;
    checkOutput("clr_capture_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("clr_capture_out_d", {29'd0, out_d}, 32'd6);
    checkOutput("clr_capture_sticky", {29'd0, sticky_d}, 32'd6);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
